// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side adapter for async_fifo, living in the rd_clk domain. It pulls
//   words out of the FIFO read port and presents them as a valid/ready stream.
//   The FIFO's one-cycle read latency is hidden behind a 2-entry skid buffer,
//   so a ready consumer receives one word per clock and word order is kept.
//
// Ports
//   rd_clk     read-domain clock
//   rd_rst_n   asynchronous active-low reset
//   empty      FIFO empty flag
//   rd_en      FIFO read strobe (combinational)
//   rd_data    FIFO read data, valid the cycle after an accepted read
//   flush      synchronous discard of buffered and in-flight words
//   out_valid  stream valid
//   out_ready  consumer accepts
//   out_data   stream data (registered, buffer entry 0)
//   word_cnt   number of words transferred on the stream (wraps)

module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [1:0]            stored_q, stored_d;     // words held in the buffer (0..2)
  logic                  inflight_q, inflight_d; // a read was accepted last edge
  logic [DATA_WIDTH-1:0] entry0_q, entry0_d;     // head of the stream
  logic [DATA_WIDTH-1:0] entry1_q, entry1_d;     // skid slot
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       pop;
  logic       capture;
  logic [1:0] occ_after_pop;
  logic [1:0] base;

  assign out_valid = (stored_q != 2'd0);
  assign out_data  = entry0_q;
  assign word_cnt  = cnt_q;

  assign pop     = out_valid && out_ready;
  // A word arriving from an in-flight read is dropped when flush is high.
  assign capture = inflight_q && !flush;

  // stored + inflight never exceeds 2, and pop implies stored >= 1, so the
  // sum fits in two bits without wrapping.
  assign occ_after_pop = stored_q + {1'b0, inflight_q} - {1'b0, pop};

  // Gated by rd_rst_n so no read is issued while reset is held, even though
  // the buffer state already reads as idle.
  assign rd_en = rd_rst_n && !empty && !flush && (occ_after_pop < 2'd2);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    stored_d   = stored_q;
    entry0_d   = entry0_q;
    entry1_d   = entry1_q;
    inflight_d = rd_en;
    cnt_d      = cnt_q + CNT_WIDTH'(pop);
    base       = stored_q - {1'b0, pop};

    if (flush) begin
      stored_d = 2'd0;
    end else begin
      if (pop) begin
        entry0_d = entry1_q;
      end
      // The captured word goes into the first free slot after the shift.
      if (capture) begin
        if (base == 2'd0) begin
          entry0_d = rd_data;
        end else begin
          entry1_d = rd_data;
        end
        stored_d = base + 2'd1;
      end else begin
        stored_d = base;
      end
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      stored_q   <= 2'd0;
      inflight_q <= 1'b0;
      // NOTE: the data entries are reset too, because entry 0 drives out_data
      // directly and must read zero out of reset.
      entry0_q   <= '0;
      entry1_q   <= '0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every flop samples
      // the pre-edge values regardless of statement order.
      stored_q   <= stored_d;
      inflight_q <= inflight_d;
      entry0_q   <= entry0_d;
      entry1_q   <= entry1_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Drives fifo_rd_stream from a queue-based FIFO model and checks the stream
//   against a scoreboard of words read out of the FIFO. A second instance
//   with a 4-bit counter shares all inputs and exposes the wrap behaviour.

module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          rd_clk    = 1'b0;
  logic          rd_rst_n  = 1'b1;
  logic          empty     = 1'b1;
  logic          flush     = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] rd_data   = '0;

  logic          rd_en, out_valid;
  logic [DW-1:0] out_data;
  logic [31:0]   word_cnt;
  logic          rd_en4, out_valid4;
  logic [DW-1:0] out_data4;
  logic [3:0]    word_cnt4;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) u_dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .empty(empty), .rd_en(rd_en),
    .rd_data(rd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .word_cnt(word_cnt)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .empty(empty), .rd_en(rd_en4),
    .rd_data(rd_data), .flush(flush), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .word_cnt(word_cnt4)
  );

  always #5 rd_clk = ~rd_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] fifo_q[$];     // words still inside the FIFO
  logic [DW-1:0] pending[$];    // words read from the FIFO, not yet delivered
  logic [DW-1:0] delivered[$];  // words seen on the stream since reset
  int unsigned   model_cnt;
  bit            stall_prev;
  logic [DW-1:0] stall_data;
  int            cyc, n_acc, n_pop;
  int            first_rd_cyc, first_vld_cyc, first_pop_cyc, last_pop_cyc;
  logic          obs_rd_en, obs_valid;
  logic [DW-1:0] obs_data;

  // One clock cycle: drive inputs at the falling edge, observe, score, and
  // apply the FIFO read latency after the rising edge.
  task automatic tick(input logic rdy, input logic fl, input logic hold);
    logic          acc, pop;
    logic [DW-1:0] w, exp_w;
    w = '0;
    @(negedge rd_clk);
    out_ready = rdy;
    flush     = fl;
    empty     = (fifo_q.size() == 0) || hold;
    #1;
    obs_rd_en = rd_en;
    obs_valid = out_valid;
    obs_data  = out_data;
    acc = rd_en && !empty;
    pop = out_valid && out_ready;

    checks++;
    if (rd_en && (empty || fl)) begin
      errors++;
      $display("FAIL rd_en_gate cyc=%0d: rd_en=%b with empty=%b flush=%b, required 0", cyc, rd_en, empty, fl);
    end

    if (stall_prev) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== stall_data) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: valid=%b data=%h, required valid=1 data=%h", cyc, out_valid, out_data, stall_data);
      end
    end

    if (pop) begin
      checks++;
      if (pending.size() == 0) begin
        errors++;
        $display("FAIL spurious_word cyc=%0d: got %h, required no valid word", cyc, out_data);
      end else begin
        exp_w = pending.pop_front();
        if (out_data !== exp_w) begin
          errors++;
          $display("FAIL stream_data cyc=%0d: got %h, required %h", cyc, out_data, exp_w);
        end
      end
      delivered.push_back(out_data);
      n_pop++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end

    checks++;
    if (word_cnt !== model_cnt || word_cnt4 !== model_cnt[3:0]) begin
      errors++;
      $display("FAIL word_cnt cyc=%0d: got %0d/%0d, required %0d/%0d", cyc, word_cnt, word_cnt4, model_cnt, model_cnt[3:0]);
    end

    checks++;
    if (rd_en4 !== rd_en || out_valid4 !== out_valid || out_data4 !== out_data) begin
      errors++;
      $display("FAIL dut4_sync cyc=%0d: dut4 rd_en=%b valid=%b data=%h, required %b %b %h", cyc, rd_en4, out_valid4, out_data4, rd_en, out_valid, out_data);
    end

    if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

    // Model update for this edge
    if (pop) model_cnt++;
    if (fl) pending.delete();
    if (acc) begin
      w = fifo_q.pop_front();
      pending.push_back(w);
      n_acc++;
    end
    checks++;
    if (pending.size() > 2) begin
      errors++;
      $display("FAIL occupancy cyc=%0d: %0d words outstanding, required <= 2", cyc, pending.size());
    end
    stall_prev = out_valid && !rdy && !fl;
    stall_data = out_data;

    @(posedge rd_clk);
    #1;
    rd_data = acc ? w : DW'($urandom);
    cyc++;
  endtask

  task automatic enter_reset(input int n, input bit rnd);
    @(negedge rd_clk);
    rd_rst_n  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fifo_q.delete();
    pending.delete();
    delivered.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? DW'($urandom) : DW'(i + 1));
    empty = (n == 0);
    model_cnt = 0;
    stall_prev = 1'b0;
    cyc = 0; n_acc = 0; n_pop = 0;
    first_rd_cyc = -1; first_vld_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
  endtask

  task automatic release_reset();
    @(posedge rd_clk);
    #1;
    rd_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge rd_clk);
    #1;
    checks++;
    if (rd_en !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || word_cnt !== '0 || word_cnt4 !== '0) begin
      errors++;
      $display("FAIL %s: rd_en=%b valid=%b data=%h cnt=%0d cnt4=%0d, required all 0", tag, rd_en, out_valid, out_data, word_cnt, word_cnt4);
    end
  endtask

  task automatic test_reset();
    enter_reset(32, 1'b0);
    repeat (3) check_reset_outputs("reset_state");
    release_reset();
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL first_rd_en: rd_en=%b in first cycle after release, required 1", obs_rd_en);
    end
    repeat (6) tick(1'b1, 1'b0, 1'b0);
    // Reset in the middle of streaming clears everything at once.
    enter_reset(32, 1'b0);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || word_cnt !== '0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: valid=%b data=%h cnt=%0d rd_en=%b, required all 0", out_valid, out_data, word_cnt, rd_en);
    end
    repeat (2) check_reset_outputs("midop_reset_hold");
  endtask

  task automatic test_stream_full();
    int  guard;
    bit  ok;
    enter_reset(32, 1'b0);
    release_reset();
    guard = 0;
    while (n_pop < 32 && guard < 80) begin
      tick(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (n_pop != 32) begin
      errors++;
      $display("FAIL full_count: delivered %0d words, required 32", n_pop);
    end
    checks++;
    if (first_vld_cyc - first_rd_cyc != 2) begin
      errors++;
      $display("FAIL full_latency: out_valid %0d cycles after rd_en, required 2", first_vld_cyc - first_rd_cyc);
    end
    checks++;
    if (last_pop_cyc - first_pop_cyc != 31) begin
      errors++;
      $display("FAIL full_throughput: 32 words over %0d cycles, required 32 consecutive", last_pop_cyc - first_pop_cyc + 1);
    end
    ok = 1'b1;
    for (int i = 0; i < 32; i++)
      if (i >= delivered.size() || delivered[i] !== DW'(i + 1)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_order: delivered sequence differs from 01..20, got %0d words", delivered.size());
    end
    @(negedge rd_clk);
    #1;
    checks++;
    if (word_cnt !== 32'd32) begin
      errors++;
      $display("FAIL full_word_cnt: got %0d, required 32", word_cnt);
    end
  endtask

  task automatic test_toggle();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int i;
    bit ok;
    enter_reset(32, 1'b0);
    release_reset();
    i = 0;
    while (n_pop < 32 && i < 300) begin
      tick(pat[i % 6], 1'b0, 1'b0);
      i++;
    end
    ok = (delivered.size() == 32);
    for (int k = 0; k < 32; k++)
      if (k >= delivered.size() || delivered[k] !== DW'(k + 1)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL toggle_order: %0d words delivered, required 01..20 once each in order", delivered.size());
    end
  endtask

  task automatic test_stall();
    enter_reset(32, 1'b0);
    release_reset();
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (n_acc != 2 || obs_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_reads: %0d reads, rd_en=%b, required 2 reads and rd_en=0", n_acc, obs_rd_en);
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h01) begin
      errors++;
      $display("FAIL stall_head: valid=%b data=%h, required valid=1 data=01", obs_valid, obs_data);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_data !== 8'h01 || obs_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: data=%h rd_en=%b, required data=01 rd_en=1", obs_data, obs_rd_en);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_data !== 8'h02 || obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_second: valid=%b data=%h, required valid=1 data=02", obs_valid, obs_data);
    end
    repeat (4) tick(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    int guard;
    enter_reset(32, 1'b0);
    release_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_valid !== 1'b1 || obs_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: valid=%b rd_en=%b, required valid=1 rd_en=0", obs_valid, obs_rd_en);
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b, required 0", obs_valid);
    end
    guard = 0;
    while (n_pop < 3 && guard < 20) begin
      tick(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (delivered.size() == 0 || delivered[0] !== 8'h03) begin
      errors++;
      $display("FAIL flush_resume: first word after flush %h (%0d words), required 03", delivered.size() ? delivered[0] : 8'h00, delivered.size());
    end
    checks++;
    if (word_cnt !== 32'(n_pop - 1) && word_cnt !== 32'(n_pop)) begin
      errors++;
      $display("FAIL flush_cnt: word_cnt=%0d, required delivered count %0d", word_cnt, n_pop);
    end
  endtask

  task automatic test_wrap();
    int guard;
    enter_reset(18, 1'b0);
    release_reset();
    guard = 0;
    while (n_pop < 18 && guard < 60) begin
      tick(1'b1, 1'b0, 1'b0);
      guard++;
    end
    @(negedge rd_clk);
    #1;
    checks++;
    if (word_cnt4 !== 4'd2 || word_cnt !== 32'd18) begin
      errors++;
      $display("FAIL wrap: cnt4=%0d cnt=%0d, required 2 and 18", word_cnt4, word_cnt);
    end
  endtask

  task automatic test_random();
    logic rdy, fl, hold;
    enter_reset(64, 1'b1);
    release_reset();
    for (int i = 0; i < 300; i++) begin
      rdy  = ($urandom % 4) != 0;
      fl   = ($urandom % 20) == 0;
      hold = ($urandom % 5) == 0;
      tick(rdy, fl, hold);
    end
    repeat (10) tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (fifo_q.size() != 0 || pending.size() != 0 || n_pop == 0) begin
      errors++;
      $display("FAIL random_drain: fifo=%0d pending=%0d delivered=%0d, required 0 0 >0", fifo_q.size(), pending.size(), n_pop);
    end
  endtask

  initial begin
    test_reset();
    test_stream_full();
    test_toggle();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Single-clock read-side adapter for the team's async_fifo.
- Drives the FIFO read port (rd_en, rd_data, empty) and presents the words as a valid/ready stream to a downstream consumer.
- Hides the FIFO's one-cycle read latency behind a 2-entry skid buffer, so sustained throughput is one word per clock and ordering is preserved.
- Sits in the rd_clk domain, directly downstream of async_fifo.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- CNT_WIDTH, 32, width of the delivered-word counter.

Ports:
- rd_clk  input  1  read-domain clock.
- rd_rst_n  input  1  asynchronous active-low reset.
- empty  input  1  FIFO empty flag, rd_clk domain.
- rd_en  output  1  FIFO read strobe.
- rd_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- flush  input  1  synchronous discard of all buffered and in-flight words.
- out_valid  output  1  stream data valid.
- out_ready  input  1  consumer accepts.
- out_data  output  DATA_WIDTH  stream data.
- word_cnt  output  CNT_WIDTH  count of words transferred on the stream.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, word_cnt=0, rd_en=0, buffer count=0, in-flight flag=0.
- Read acceptance: a read is accepted when rd_en=1 and empty=0 at a rd_clk edge. rd_data is captured at the next edge (in-flight flag set for exactly one cycle).
- rd_en is combinational: rd_en = !empty && !flush && (stored + inflight - pop) < 2, where pop = out_valid && out_ready.
- rd_en never asserts when empty=1 (no underflow reads).
- Buffer: 2 entries, FIFO order. out_data is driven from a register (entry 0); entry 1 is the skid slot.
- Capture: if a pop and a capture happen in the same cycle, the captured word goes to the slot vacated by the shift.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold stable.
- Latency: empty falling with the buffer idle and out_ready=1 gives rd_en in the same cycle and out_valid two edges later.
- Throughput: one word per cycle in steady state (stored=1, inflight=1, pop=1).
- Stall: on out_ready=0 the in-flight word lands in the skid slot, rd_en drops, and no data is lost.
- word_cnt increments by 1 per pop and wraps modulo 2^CNT_WIDTH with no saturation.
- Flush (synchronous): at the flush edge, stored=0 and out_valid=0, and any word arriving from an in-flight read is discarded.
  - rd_en=0 during any cycle with flush=1.
  - A pop in the flush cycle is still counted; word_cnt is otherwise unaffected.
- Simultaneous capture, pop and new read are all legal in one cycle; the occupancy bound is never exceeded (stored ≤ 2).
- Reset mid-operation clears all state immediately; words in flight are lost.

Test Plan:
- Reset with empty=0 → rd_en=0, out_valid=0, out_data=0, word_cnt=0 until rd_rst_n releases; first rd_en in the first cycle after release.
- FIFO holds 0x01..0x20 (32 words), out_ready=1 constantly → out_data=0x01..0x20 on 32 consecutive cycles, first at 2 edges after the first rd_en; word_cnt=32; rd_en never high while empty=1.
- Streaming with out_ready toggled 1,0,0,1,0,1… → every value 0x01..0x20 appears exactly once in order; out_data stable during stalls; never more than 2 reads outstanding beyond accepted pops.
- out_ready=0 from the start, FIFO non-empty → exactly 2 reads issued, then rd_en=0; out_valid=1 holding 0x01; releasing out_ready delivers 0x01, then 0x02, then reads resume.
- Flush asserted one cycle after rd_en, with 1 word stored → next cycle out_valid=0 and the in-flight word is discarded; the subsequent stream resumes with the next FIFO word; word_cnt unchanged by the flush.
- Preload word_cnt path with CNT_WIDTH=4, transfer 18 words → word_cnt wraps to 2.
